// File: rtl/mux_scan_pkg.sv
// Shared state and mode encodings for the mux_scan block and its helpers.
package mux_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MANUAL = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_scan_next.sv
// Round-robin finder: first enabled index after cur (cur+1 .. cur, modulo CHANNELS).
module mux_scan_next #(
    parameter  int unsigned CHANNELS = 4,
    localparam int unsigned SEL_W    = $clog2(CHANNELS)
) (
    input  logic [SEL_W-1:0]    cur,
    input  logic [CHANNELS-1:0] ch_mask,
    output logic [SEL_W-1:0]    next,
    output logic                found,
    output logic                wrapped
);

    int unsigned idx;

    // Search from the farthest candidate down so the nearest enabled one wins.
    always_comb begin
        next  = cur;
        found = 1'b0;
        idx   = 0;
        for (int k = int'(CHANNELS); k >= 1; k--) begin
            idx = 32'(cur) + 32'(k);
            if (idx >= CHANNELS) begin
                idx = idx - CHANNELS;
            end
            if (ch_mask[SEL_W'(idx)]) begin
                next  = SEL_W'(idx);
                found = 1'b1;
            end
        end
        wrapped = found && (next <= cur);
    end

endmodule

// File: rtl/mux_scan.sv
// N-channel registered mux with manual select and auto-scan over enabled channels.
// Define MUX_SCAN_PIPE_EN to add a second, aligned output register stage.
module mux_scan
    import mux_scan_pkg::*;
#(
    parameter  int unsigned WIDTH    = 8,
    parameter  int unsigned CHANNELS = 4,
    parameter  int unsigned DWELL    = 4,
    localparam int unsigned SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] din,
    input  logic                      en,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS-1:0]       ch_mask,
    output logic [WIDTH-1:0]          dout,
    output logic [SEL_W-1:0]          dout_ch,
    output logic                      dout_valid,
    output logic                      wrap
);

    localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   cur_q, cur_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, eff_cnt;
    logic [WIDTH-1:0]   s1_dout, dout_d;
    logic [SEL_W-1:0]   s1_ch, ch_d;
    logic               s1_valid, valid_d;
    logic               s1_wrap, wrap_d;
    logic               sel_ok;
    logic [SEL_W-1:0]   nxt;
    logic               found, wrapped;
    logic [WIDTH-1:0]   ch_data [CHANNELS];

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        assign ch_data[i] = din[i*WIDTH +: WIDTH];
    end

    mux_scan_next #(.CHANNELS(CHANNELS)) u_next (
        .cur     (cur_q),
        .ch_mask (ch_mask),
        .next    (nxt),
        .found   (found),
        .wrapped (wrapped)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cur_q    <= '0;
            cnt_q    <= '0;
            s1_dout  <= '0;
            s1_ch    <= '0;
            s1_valid <= 1'b0;
            s1_wrap  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            cnt_q    <= cnt_d;
            s1_dout  <= dout_d;
            s1_ch    <= ch_d;
            s1_valid <= valid_d;
            s1_wrap  <= wrap_d;
        end
    end

    // The action at each edge follows en/mode; state_q only marks scan entry (dwell restarts).
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        dout_d  = s1_dout;
        ch_d    = s1_ch;
        valid_d = 1'b0;
        wrap_d  = 1'b0;
        sel_ok  = (32'(sel) < CHANNELS);
        eff_cnt = (state_q == ST_SCAN) ? cnt_q : '0;

        if (!en) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (mode == MODE_MANUAL) begin
            state_d = ST_MANUAL;
            cnt_d   = '0;
            if (sel_ok) begin
                cur_d = sel;
                if (ch_mask[sel]) begin
                    dout_d  = ch_data[sel];
                    ch_d    = sel;
                    valid_d = 1'b1;
                end
            end
        end else begin
            state_d = ST_SCAN;
            if (!found) begin
                cnt_d = eff_cnt;
            end else begin
                dout_d  = ch_data[cur_q];
                ch_d    = cur_q;
                valid_d = ch_mask[cur_q];
                if (!ch_mask[cur_q] || eff_cnt == CNT_W'(DWELL - 1)) begin
                    cur_d  = nxt;
                    cnt_d  = '0;
                    wrap_d = wrapped;
                end else begin
                    cnt_d = eff_cnt + CNT_W'(1);
                end
            end
        end
    end

`ifdef MUX_SCAN_PIPE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout       <= '0;
            dout_ch    <= '0;
            dout_valid <= 1'b0;
            wrap       <= 1'b0;
        end else begin
            dout       <= s1_dout;
            dout_ch    <= s1_ch;
            dout_valid <= s1_valid;
            wrap       <= s1_wrap;
        end
    end
`else
    assign dout       = s1_dout;
    assign dout_ch    = s1_ch;
    assign dout_valid = s1_valid;
    assign wrap       = s1_wrap;
`endif

endmodule

// File: tb/tb_mux_scan.sv
// Scoreboard bench for mux_scan (WIDTH=8, CHANNELS=4, DWELL=4), either latency build.
module tb_mux_scan;

`ifdef MUX_SCAN_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int DWELL = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] din;
    logic        en, mode;
    logic [1:0]  sel;
    logic [3:0]  ch_mask;
    logic [7:0]  dout;
    logic [1:0]  dout_ch;
    logic        dout_valid, wrap;

    wire [11:0] obs_w = {dout, dout_ch, dout_valid, wrap};

    int n_tests = 0;
    int n_fail  = 0;
    logic [11:0] sb[$];
    logic [11:0] expv;

    // Reference model state
    int   m_state, m_cur, m_cnt, m_ch;
    logic [7:0] m_dout;
    bit   m_valid, m_wrap;

    mux_scan #(.WIDTH(8), .CHANNELS(4), .DWELL(DWELL)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .en(en), .mode(mode), .sel(sel),
        .ch_mask(ch_mask), .dout(dout), .dout_ch(dout_ch), .dout_valid(dout_valid), .wrap(wrap)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_state = 0; m_cur = 0; m_cnt = 0; m_ch = 0; m_dout = 8'h00;
        sb.delete();
        for (int i = 0; i < LAT - 1; i++) sb.push_back(12'h000);
    endtask

    task automatic model_step();
        int ec, nx;
        m_valid = 0;
        m_wrap  = 0;
        ec = (m_state == 2) ? m_cnt : 0;
        if (!en) begin
            m_state = 0; m_cnt = 0;
        end else if (!mode) begin
            m_state = 1; m_cnt = 0; m_cur = int'(sel);
            if (ch_mask[sel]) begin
                m_dout = din[sel*8 +: 8]; m_ch = int'(sel); m_valid = 1;
            end
        end else begin
            m_state = 2;
            if (ch_mask == 4'b0000) begin
                m_cnt = ec;
            end else begin
                m_dout  = din[m_cur*8 +: 8];
                m_ch    = m_cur;
                m_valid = ch_mask[m_cur];
                if (!ch_mask[m_cur] || ec == DWELL - 1) begin
                    nx = m_cur;
                    do nx = (nx + 1) % 4; while (!ch_mask[nx]);
                    m_wrap = (nx <= m_cur);
                    m_cur  = nx;
                    m_cnt  = 0;
                end else begin
                    m_cnt = ec + 1;
                end
            end
        end
        sb.push_back({m_dout, 2'(m_ch), m_valid, m_wrap});
    endtask

    // One clock: predict from current inputs, advance, settle past the edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        n_tests++;
        if (obs_w !== 12'h000) begin
            n_fail++; $display("FAIL reset_state got=%h want=000", obs_w);
        end
        #4 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); expv = sb.pop_front(); n_tests++;
            if (obs_w !== expv) begin n_fail++; $display("FAIL reset_idle_sb got=%h want=%h", obs_w, expv); end
        end
    endtask

    task automatic test_manual();
        din = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        en = 1'b1; mode = 1'b0; ch_mask = 4'b1111; sel = 2'd2;
        for (int i = 0; i < LAT; i++) begin
            tick(); expv = sb.pop_front(); n_tests++;
            if (obs_w !== expv) begin n_fail++; $display("FAIL manual_sb got=%h want=%h", obs_w, expv); end
        end
        n_tests++;
        if ({dout, dout_ch, dout_valid} !== {8'hC2, 2'd2, 1'b1}) begin
            n_fail++; $display("FAIL manual_sel2 got=%h/%0d/%b want=c2/2/1", dout, dout_ch, dout_valid);
        end
        sel = 2'd1; ch_mask = 4'b1101;
        for (int i = 0; i < LAT; i++) begin
            tick(); expv = sb.pop_front(); n_tests++;
            if (obs_w !== expv) begin n_fail++; $display("FAIL manual_mask_sb got=%h want=%h", obs_w, expv); end
        end
        n_tests++;
        if ({dout, dout_ch, dout_valid} !== {8'hC2, 2'd2, 1'b0}) begin
            n_fail++; $display("FAIL manual_masked got=%h/%0d/%b want=c2/2/0", dout, dout_ch, dout_valid);
        end
        sel = 2'd3; ch_mask = 4'b1111;
        for (int i = 0; i < LAT; i++) begin
            tick(); expv = sb.pop_front(); n_tests++;
            if (obs_w !== expv) begin n_fail++; $display("FAIL manual_sel3_sb got=%h want=%h", obs_w, expv); end
        end
        n_tests++;
        if ({dout, dout_ch, dout_valid} !== {8'hD3, 2'd3, 1'b1}) begin
            n_fail++; $display("FAIL manual_sel3 got=%h/%0d/%b want=d3/3/1", dout, dout_ch, dout_valid);
        end
        en = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            tick(); expv = sb.pop_front(); n_tests++;
            if (obs_w !== expv) begin n_fail++; $display("FAIL disable_sb got=%h want=%h", obs_w, expv); end
        end
        n_tests++;
        if ({dout, dout_valid} !== {8'hD3, 1'b0}) begin
            n_fail++; $display("FAIL disable_hold got=%h/%b want=d3/0", dout, dout_valid);
        end
    endtask

    task automatic test_scan();
        logic [1:0] exp_ch [13] = '{0,0,0,0,1,1,1,1,3,3,3,3,0};
        logic [1:0] oc [16];
        logic       ov [16];
        logic       ow [16];
        en = 1'b1; mode = 1'b0; sel = 2'd0; ch_mask = 4'b1011;
        tick(); expv = sb.pop_front(); n_tests++;
        if (obs_w !== expv) begin n_fail++; $display("FAIL scan_pre_sb got=%h want=%h", obs_w, expv); end
        mode = 1'b1;
        for (int i = 0; i < 12 + LAT; i++) begin
            tick(); expv = sb.pop_front(); n_tests++;
            if (obs_w !== expv) begin n_fail++; $display("FAIL scan_sb got=%h want=%h", obs_w, expv); end
            oc[i] = dout_ch; ov[i] = dout_valid; ow[i] = wrap;
        end
        for (int i = 0; i < 13; i++) begin
            n_tests++;
            if ({oc[i+LAT-1], ov[i+LAT-1], ow[i+LAT-1]} !== {exp_ch[i], 1'b1, (i == 11) ? 1'b1 : 1'b0}) begin
                n_fail++;
                $display("FAIL scan_order[%0d] got ch=%0d v=%b w=%b want ch=%0d v=1 w=%b",
                         i, oc[i+LAT-1], ov[i+LAT-1], ow[i+LAT-1], exp_ch[i], (i == 11));
            end
        end
    endtask

    task automatic test_mask_mid();
        logic [1:0] exp_ch [6] = '{1,1,3,3,3,3};
        logic       exp_v  [6] = '{1,0,1,1,1,1};
        logic [1:0] oc [8];
        logic       ov [8];
        logic       ow [8];
        mode = 1'b0; sel = 2'd1; ch_mask = 4'b1011;
        tick(); expv = sb.pop_front(); n_tests++;
        if (obs_w !== expv) begin n_fail++; $display("FAIL maskmid_pre_sb got=%h want=%h", obs_w, expv); end
        mode = 1'b1;
        for (int i = 0; i < 5 + LAT; i++) begin
            if (i == 1) ch_mask = 4'b1001;
            tick(); expv = sb.pop_front(); n_tests++;
            if (obs_w !== expv) begin n_fail++; $display("FAIL maskmid_sb got=%h want=%h", obs_w, expv); end
            oc[i] = dout_ch; ov[i] = dout_valid; ow[i] = wrap;
        end
        for (int i = 0; i < 6; i++) begin
            n_tests++;
            if ({oc[i+LAT-1], ov[i+LAT-1], ow[i+LAT-1]} !== {exp_ch[i], exp_v[i], (i == 5) ? 1'b1 : 1'b0}) begin
                n_fail++;
                $display("FAIL maskmid[%0d] got ch=%0d v=%b w=%b want ch=%0d v=%b w=%b",
                         i, oc[i+LAT-1], ov[i+LAT-1], ow[i+LAT-1], exp_ch[i], exp_v[i], (i == 5));
            end
        end
    endtask

    task automatic test_degenerate();
        int wraps = 0;
        ch_mask = 4'b0000;
        for (int i = 0; i < 6; i++) begin
            tick(); expv = sb.pop_front(); n_tests++;
            if (obs_w !== expv) begin n_fail++; $display("FAIL allmask_sb got=%h want=%h", obs_w, expv); end
            if (i >= LAT) begin
                n_tests++;
                if ({dout_valid, wrap} !== 2'b00) begin
                    n_fail++; $display("FAIL allmask_quiet got v=%b w=%b want 0/0", dout_valid, wrap);
                end
            end
        end
        ch_mask = 4'b0100;
        for (int i = 0; i < 1 + LAT + 16; i++) begin
            tick(); expv = sb.pop_front(); n_tests++;
            if (obs_w !== expv) begin n_fail++; $display("FAIL single_sb got=%h want=%h", obs_w, expv); end
            if (i >= 1 + LAT) begin
                n_tests++;
                if ({dout_ch, dout_valid} !== {2'd2, 1'b1}) begin
                    n_fail++; $display("FAIL single_ch got ch=%0d v=%b want 2/1", dout_ch, dout_valid);
                end
                if (wrap) wraps++;
            end
        end
        n_tests++;
        if (wraps !== 4) begin n_fail++; $display("FAIL single_wraps got=%0d want=4", wraps); end
    endtask

    task automatic test_reset_mid();
        logic [1:0] oc [8];
        logic       ov [8];
        din = 32'h4433_2211; en = 1'b1; mode = 1'b1; ch_mask = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            tick(); expv = sb.pop_front(); n_tests++;
            if (obs_w !== expv) begin n_fail++; $display("FAIL prereset_sb got=%h want=%h", obs_w, expv); end
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (obs_w !== 12'h000) begin n_fail++; $display("FAIL async_reset got=%h want=000", obs_w); end
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 4 + LAT; i++) begin
            tick(); expv = sb.pop_front(); n_tests++;
            if (obs_w !== expv) begin n_fail++; $display("FAIL postreset_sb got=%h want=%h", obs_w, expv); end
            oc[i] = dout_ch; ov[i] = dout_valid;
        end
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if ({oc[i+LAT-1], ov[i+LAT-1]} !== {(i == 4) ? 2'd1 : 2'd0, 1'b1}) begin
                n_fail++; $display("FAIL postreset_ch[%0d] got ch=%0d v=%b want ch=%0d v=1",
                                   i, oc[i+LAT-1], ov[i+LAT-1], (i == 4) ? 1 : 0);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 300; i++) begin
            din = $urandom();
            en  = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0) mode = ~mode;
            if ($urandom_range(0, 3) == 0) sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) ch_mask = 4'($urandom_range(0, 15));
            tick(); expv = sb.pop_front(); n_tests++;
            if (obs_w !== expv) begin n_fail++; $display("FAIL random_sb[%0d] got=%h want=%h", i, obs_w, expv); end
        end
    endtask

    initial begin
        rst_n = 1'b0; din = '0; en = 1'b0; mode = 1'b0; sel = 2'd0; ch_mask = 4'b0000;
        model_reset();
        test_reset();
        test_manual();
        test_scan();
        test_mask_mid();
        test_degenerate();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_scan.md
Name: mux_scan

Overview:
- Parametrised N-channel, WIDTH-bit multiplexer with a registered output. Successor to the basic 2:1 combinational mux.
- Two modes. Manual: an external select picks the channel. Auto-scan: an internal FSM and dwell counter step through the enabled channels.
- Sits between multi-channel data sources (sensor/ADC words, test patterns) and a single downstream consumer. Reports which channel is presented and whether it is valid.

Parameters:
- WIDTH, 8, data width per channel (>=1)
- CHANNELS, 4, number of input channels (>=2)
- DWELL, 4, cycles each channel is held in auto-scan (>=1)
- SEL_W, localparam = $clog2(CHANNELS), select/index width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous reset, active-low
- din  in  CHANNELS*WIDTH  packed inputs; channel i = din[i*WIDTH +: WIDTH]
- en  in  1  block enable; 0 = hold outputs, dout_valid=0
- mode  in  1  0 = manual, 1 = auto-scan
- sel  in  SEL_W  manual channel select
- ch_mask  in  CHANNELS  1 = channel enabled
- dout  out  WIDTH  selected data, registered
- dout_ch  out  SEL_W  index of channel on dout
- dout_valid  out  1  dout holds a valid enabled-channel sample
- wrap  out  1  one-cycle pulse when scan index wraps

Behaviour:
- Reset (async, rst_n=0): state=IDLE, cur=0, cnt=0, dout=0, dout_ch=0, dout_valid=0, wrap=0.
- FSM states: IDLE, MANUAL, SCAN. Evaluated every rising edge.
  - en=0 -> IDLE from any state.
  - en=1 & mode=0 -> MANUAL.
  - en=1 & mode=1 -> SCAN.
- IDLE: dout and dout_ch hold their last values; dout_valid=0; cnt=0; cur holds.
- MANUAL: 1-cycle latency. At each edge, dout<=din[sel], dout_ch<=sel, cur<=sel.
  - dout_valid<=1 only if sel<CHANNELS and ch_mask[sel]=1.
  - Otherwise dout_valid<=0 and dout/dout_ch hold.
- SCAN entry (from IDLE or MANUAL): start at cur, cnt=0; no wrap pulse on entry.
- SCAN: each cycle dout<=din[cur], dout_ch<=cur, dout_valid<=ch_mask[cur]; cnt increments.
  - When cnt==DWELL-1, or ch_mask[cur]==0: cur<=next, cnt<=0.
  - next = first enabled index searching cur+1, cur+2, … modulo CHANNELS, ending at cur itself.
- wrap: pulses 1 in the cycle cur advances to next<=cur (crossed CHANNELS-1). A single enabled channel produces a wrap every DWELL cycles.
- All-masked (ch_mask=0) in SCAN: cur and cnt hold, dout_valid=0, wrap=0.
- Masked channel mid-dwell: advance on the next edge without waiting out the dwell.
- Mode change mid-dwell: takes effect at the next edge; cnt resets to 0.
- din sampled live each cycle; the block never latches data outside the dout register.

Optional Feature:
- Macro: MUX_SCAN_PIPE_EN.
- Defined: one extra output register stage on dout, dout_ch, dout_valid and wrap. Latency from din/sel becomes 2 cycles; all four outputs stay mutually aligned; extra stage resets to 0.
- Undefined: latency 1 as above.

Decomposition:
- Package mux_scan_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_MANUAL=2'd1, ST_SCAN=2'd2
  - MODE_MANUAL/MODE_SCAN constants
- Sub-module mux_scan_next: combinational round-robin next-enabled-index finder.
  - Inputs: cur, ch_mask. Outputs: next, found, wrapped.
  - Reusable by future arbiters; unit-testable alone.

Test Plan (WIDTH=8, CHANNELS=4, DWELL=4 unless noted):
- Reset mid-scan: rst_n low for 1 ns at arbitrary time -> all outputs 0 immediately, independent of clk; after release with en=1, mode=1, mask=4'b1111 -> dout_ch 0 for 4 cycles.
- Manual select: din={8'hD3,8'hC2,8'hB1,8'hA0}, mask=4'b1111, sel=2 -> next edge dout=8'hC2, dout_ch=2, valid=1; sel=1 with mask=4'b1101 -> valid=0, dout holds 8'hC2.
- Scan order and wrap: mode=1, mask=4'b1011 -> dout_ch sequence 0,0,0,0,1,1,1,1,3,3,3,3,0…; wrap=1 exactly on the cycle cur goes 3->0.
- Mask change mid-dwell: scanning ch1 at cnt=1, clear mask[1] -> next edge cur=3, valid=0 for that sample, cnt restarts.
- Degenerate masks: mask=4'b0000 -> valid stays 0, cur frozen, no wrap; mask=4'b0100 -> dout_ch=2 constantly, wrap every 4 cycles.
- MUX_SCAN_PIPE_EN defined: manual sel=3 -> dout=din[3] exactly 2 edges later; en=0 -> valid low 2 edges later.
